// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial add sequencer with start/busy/done handshake. It
//            feeds one full-adder bit per clock, LSB first. Define
//            SERADD_SUB_EN to add the sub port for A-B.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sbit;
    logic             w_cnext;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    assign w_accept = (r_state != ST_RUN) && start && !abort;
    assign w_last   = (r_cnt == C_LAST_BIT);
    assign w_sbit   = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext  = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

`ifdef SERADD_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign w_b_load = sub ? ~B : B;
    assign w_c_load = sub | CIN;
`else
    assign w_b_load = B;
    assign w_c_load = CIN;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN: begin
                if (abort)       w_state_next = ST_IDLE;
                else if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = w_accept ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            busy <= (w_state_next != ST_IDLE);
            done <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_a   <= A;
                r_b   <= w_b_load;
                r_c   <= w_c_load;
                r_cnt <= '0;
            end else if (r_state == ST_RUN && !abort) begin
                r_a   <= {1'b0, r_a[WIDTH-1:1]};
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                r_sum <= {w_sbit, r_sum[WIDTH-1:1]};
                r_c   <= w_cnext;
                r_cnt <= r_cnt + CNT_W'(1);
                // On the final bit r_c still holds the carry into the MSB.
                if (w_last) begin
                    S    <= {w_sbit, r_sum[WIDTH-1:1]};
                    COUT <= w_cnext;
                    OVF  <= r_c ^ w_cnext;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Directed vector bench for serial_add_ctrl at WIDTH=8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST   (rst),
        .start (start),
        .abort (abort),
        .CIN   (cin),
        .A     (a),
        .B     (b),
`ifdef SERADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (s),
        .COUT  (cout),
        .OVF   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_s;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one single-cycle start and returns cycles from accept edge to done.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic vsub, output int lat);
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t vecs[$];
    int   lat;
    int   first_done;
    int   second_done;
    bit   saw_done;

    initial begin
        vecs.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'hA5, 8'h0F, 1'b1, 1'b0, 8'hB5, 1'b0, 1'b0});
`ifdef SERADD_SUB_EN
        vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_S", s, 0);
        chk("reset_COUT", cout, 0);
        chk("reset_OVF", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_S", i), s, vecs[i].exp_s);
            chk($sformatf("v%0d_COUT", i), cout, vecs[i].exp_cout);
            chk($sformatf("v%0d_OVF", i), ovf, vecs[i].exp_ovf);
            chk($sformatf("v%0d_busy_in_done", i), busy, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
        end

        // Start held high: the second operation is accepted in the DONE cycle.
        @(negedge clk);
        a = 8'h00; b = 8'h00; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        first_done = -1;
        second_done = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_done < 0) begin
                    first_done = k;
                    chk("b2b_busy_in_done", busy, 1);
                end else begin
                    second_done = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", first_done, 8);
        chk("b2b_second_done", second_done, 17);
        chk("b2b_S", s, 8'h01);
        @(posedge clk);
        #1;
        chk("b2b_idle_after", busy, 0);

        // Start ignored during RUN, then abort at bit 5.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_S_kept", s, 8'h01);
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done_later", saw_done, 0);

        // Abort in IDLE blocks a simultaneous start.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("abort_blocks_start", busy, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", s, 0);
        chk("rst_COUT", cout, 0);
        chk("rst_OVF", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_S", s, 8'h46);
        chk("post_rst_COUT", cout, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
